multi_push_multi_pop_fifo_sync: RTL and testbench
=================================================

# multi_push_multi_pop_fifo_sync

Synchronous circular FIFO that accepts 0..NI words per cycle on a lane-packed push port and releases 0..NO words per cycle on a lane-packed pop port. The head words are exposed first-word-fall-through. Used in the UART/DSP datapath wherever a producer and a consumer move variable-size word groups per clock. All flow control is credit-style: the block advertises how many words it can take and give this cycle, and the neighbours never exceed those counts.

## Interface
Parameters:
- W, 8: data word width in bits.
- D, 4: storage depth in words; any integer ≥ 1, power of two not required.
- NI, 4: maximum words pushed per cycle.
- NO, 4: maximum words popped per cycle.
- Derived: WI = $clog2(NI+1), WO = $clog2(NO+1), WC = $clog2(D+1).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- push  in  WI  number of words to write this cycle, 0..NI.
- push_data  in  [NI][W]  lane i carries the i-th word pushed; lane 0 is the oldest.
- pop  in  WO  number of words to remove this cycle, 0..NO.
- pop_data  out  [NO][W]  lane i shows the word at head+i; lane 0 is the oldest stored word.
- can_push  out  WI  words acceptable this cycle = min(NI, D − count).
- can_pop  out  WO  words available this cycle = min(NO, count).

## Operation
- State: circular memory mem[D], write pointer wp, read pointer rp, occupancy count (WC bits).
- Effective counts:
  - push_eff = min(push, can_push).
  - pop_eff = min(pop, can_pop).
  - Over-requests are clamped silently and never corrupt state.
- Write: for i < push_eff, mem[(wp+i) mod D] ← push_data[i]. Then wp ← (wp+push_eff) mod D. Lanes ≥ push_eff are ignored.
- Read: pop_data[i] = mem[(rp+i) mod D] for every lane i, driven combinationally from registered state. Only lanes i < can_pop hold valid data; the other lanes show stale memory contents.
- Pop: rp ← (rp+pop_eff) mod D.
- Count: count ← count + push_eff − pop_eff.
- Pointer wrap: use a compare-and-subtract (if sum ≥ D, subtract D). The sum is at most 2D−1, so one subtraction suffices. Do not rely on power-of-two masking.
- Simultaneous push and pop in one cycle are both performed. can_push and can_pop use the count at the start of the cycle; space freed by a same-cycle pop is not usable until the next cycle.
- Full: can_push = 0 and all pushes are dropped. Empty: can_pop = 0 and all pops are ignored.

## Timing
- On reset, applied at any time including mid-operation:
  - wp, rp and count are cleared to 0.
  - All mem entries are cleared to 0.
  - can_pop = 0, can_push = min(NI, D), pop_data is all 0.
- Reset takes priority over push and pop in the same cycle.
- Write-to-read latency is 1 cycle. A word pushed at edge k appears on pop_data and in can_pop after edge k.
- A pop at edge k exposes the next word on lane 0 after edge k.
- can_push, can_pop and pop_data depend only on registered state. There is no combinational path from push or pop to any output.

## Test plan
With defaults W=8, D=4, NI=NO=4:
- Reset check: hold rst high for 3 cycles -> can_pop=0, can_push=4, pop_data all 0, all pushes and pops ignored.
- Multi-push then single pops:
  - push=3 with data {1,2,3,4} -> next cycle can_pop=3, can_push=1, pop_data[0..2]=1,2,3.
  - Then pop=1 for three cycles -> lane 0 shows 2, then 3, then can_pop=0 and can_push=4.
- Wrap-around: continuing from the state above (rp=wp=3), push=3 with {6,7,8,9} -> pop_data[0..2]=6,7,8.
  - Then pop=2 -> can_pop=1, pop_data[0]=8, can_push=3.
- Full and overflow clamp: from empty, push=4 with {A,B,C,D} -> can_push=0.
  - Then push=2 with new data -> contents are unchanged and count stays 4.
  - Then pop=4 -> words come out A,B,C,D in order.
- Simultaneous push and pop: with count=2, push=2 and pop=1 in the same cycle -> count=3, order preserved, can_push=1.
  - Also, with count=4, push=1 and pop=1 -> the push is clamped to 0 and count=3.
- Underflow clamp and reset mid-operation:
  - With count=1, pop=3 -> count=0, no pointer corruption, and a later push/pop returns the correct data.
  - Asserting rst with count=3 -> next cycle state matches the reset check above.

Source files
------------

// File: rtl/multi_push_multi_pop_fifo_sync.sv
// rtl/multi_push_multi_pop_fifo_sync.sv - circular FIFO with variable-width push and pop per cycle
// Credit-style flow control; head words exposed first-word-fall-through on lane-packed outputs.
module multi_push_multi_pop_fifo_sync #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int NI = 4,
    parameter int NO = 4,
    parameter int WI = $clog2(NI + 1),
    parameter int WO = $clog2(NO + 1),
    parameter int WC = $clog2(D + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WI-1:0]   push,
    input  logic [NI*W-1:0] push_data,
    input  logic [WO-1:0]   pop,
    output logic [NO*W-1:0] pop_data,
    output logic [WI-1:0]   can_push,
    output logic [WO-1:0]   can_pop
);

    localparam int PW = (D > 1) ? $clog2(D) : 1;

    // Operand never exceeds 2D-1, so a single compare-and-subtract wraps it.
    function automatic int wrap(input int s);
        return (s >= D) ? s - D : s;
    endfunction

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [WC-1:0] count_q, count_d;

    int free_w;
    int cp_w;
    int cq_w;
    int push_eff;
    int pop_eff;

    always_comb begin
        free_w   = D - int'(count_q);
        cp_w     = (free_w < NI) ? free_w : NI;
        cq_w     = (int'(count_q) < NO) ? int'(count_q) : NO;
        push_eff = (int'(push) < cp_w) ? int'(push) : cp_w;
        pop_eff  = (int'(pop) < cq_w) ? int'(pop) : cq_w;

        mem_d = mem_q;
        for (int i = 0; i < NI; i++) begin
            if (i < push_eff) begin
                mem_d[PW'(wrap(int'(wp_q) + (i % D)))] = push_data[i*W +: W];
            end
        end

        wp_d    = PW'(wrap(int'(wp_q) + push_eff));
        rp_d    = PW'(wrap(int'(rp_q) + pop_eff));
        count_d = WC'(int'(count_q) + push_eff - pop_eff);

        can_push = WI'(cp_w);
        can_pop  = WO'(cq_w);

        // Lanes beyond can_pop still show whatever sits in memory there.
        pop_data = '0;
        for (int i = 0; i < NO; i++) begin
            pop_data[i*W +: W] = mem_q[PW'(wrap(int'(rp_q) + (i % D)))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int j = 0; j < D; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            for (int j = 0; j < D; j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

endmodule

// File: tb/tb_multi_push_multi_pop_fifo_sync.sv
// tb/tb_multi_push_multi_pop_fifo_sync.sv - scoreboard bench for multi_push_multi_pop_fifo_sync
// Driver queues hand-computed status and lane words; a negedge monitor compares them.
module tb_multi_push_multi_pop_fifo_sync;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int WI = $clog2(NI + 1);
    localparam int WO = $clog2(NO + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [WI-1:0]   push = '0;
    logic [NI*W-1:0] push_data = '0;
    logic [WO-1:0]   pop = '0;
    logic [NO*W-1:0] pop_data;
    logic [WI-1:0]   can_push;
    logic [WO-1:0]   can_pop;

    multi_push_multi_pop_fifo_sync #(.W(W), .D(D), .NI(NI), .NO(NO)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .can_push  (can_push),
        .can_pop   (can_pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int cp;
        int cq;
        int n;
    } st_t;

    st_t        st_q[$];
    logic [7:0] data_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         step_id = 0;

    // Expected values describe the state visible during the cycle being driven.
    task automatic step(input bit r, input int pu, input logic [31:0] pd, input int po,
                        input int ecp, input int ecq, input int n, input logic [31:0] ev);
        st_t s;
        @(posedge clk);
        #1;
        rst       = r;
        push      = WI'(pu);
        push_data = pd;
        pop       = WO'(po);
        s.id = step_id;
        s.cp = ecp;
        s.cq = ecq;
        s.n  = n;
        st_q.push_back(s);
        for (int i = 0; i < n; i++) data_q.push_back(ev[i*8 +: 8]);
        step_id++;
    endtask

    initial begin : monitor
        st_t        s;
        logic [7:0] exp_w;
        logic [7:0] got_w;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                n_cmp++;
                if (int'(can_push) != s.cp) begin
                    n_mis++;
                    $display("FAIL can_push step %0d: got %0d want %0d", s.id, can_push, s.cp);
                end
                n_cmp++;
                if (int'(can_pop) != s.cq) begin
                    n_mis++;
                    $display("FAIL can_pop step %0d: got %0d want %0d", s.id, can_pop, s.cq);
                end
                for (int i = 0; i < s.n; i++) begin
                    exp_w = data_q.pop_front();
                    got_w = pop_data[i*W +: W];
                    n_cmp++;
                    if (got_w !== exp_w) begin
                        n_mis++;
                        $display("FAIL pop_data[%0d] step %0d: got %h want %h", i, s.id, got_w, exp_w);
                    end
                end
            end
        end
    end

    initial begin : driver
        int waited;
        // reset held three cycles with traffic that must be ignored
        step(1, 4, 32'h0e0d0c0b, 4, 4, 0, 4, 32'h00000000);
        step(1, 4, 32'h0e0d0c0b, 4, 4, 0, 4, 32'h00000000);
        step(1, 4, 32'h0e0d0c0b, 4, 4, 0, 4, 32'h00000000);
        // multi-push then single pops
        step(0, 3, 32'h04030201, 0, 4, 0, 4, 32'h00000000);
        step(0, 0, 32'h0,        1, 1, 3, 3, 32'h00030201);
        step(0, 0, 32'h0,        1, 2, 2, 1, 32'h00000002);
        step(0, 0, 32'h0,        1, 3, 1, 1, 32'h00000003);
        // wrap-around from rp=wp=3
        step(0, 3, 32'h09080706, 0, 4, 0, 0, 32'h0);
        step(0, 0, 32'h0,        2, 1, 3, 3, 32'h00080706);
        step(0, 0, 32'h0,        0, 3, 1, 1, 32'h00000008);
        step(0, 0, 32'h0,        1, 3, 1, 1, 32'h00000008);
        // full and overflow clamp
        step(0, 4, 32'hd0c0b0a0, 0, 4, 0, 0, 32'h0);
        step(0, 2, 32'h88776655, 0, 0, 4, 4, 32'hd0c0b0a0);
        step(0, 0, 32'h0,        4, 0, 4, 4, 32'hd0c0b0a0);
        // simultaneous push and pop
        step(0, 2, 32'h00002221, 0, 4, 0, 0, 32'h0);
        step(0, 2, 32'h00002423, 1, 2, 2, 2, 32'h00002221);
        step(0, 0, 32'h0,        0, 1, 3, 3, 32'h00242322);
        step(0, 1, 32'h00000025, 0, 1, 3, 3, 32'h00242322);
        step(0, 1, 32'h00000026, 1, 0, 4, 4, 32'h25242322);
        step(0, 0, 32'h0,        0, 1, 3, 3, 32'h00252423);
        // underflow clamp
        step(0, 0, 32'h0,        2, 1, 3, 3, 32'h00252423);
        step(0, 0, 32'h0,        3, 3, 1, 1, 32'h00000025);
        step(0, 2, 32'h00003231, 0, 4, 0, 0, 32'h0);
        step(0, 1, 32'h00000033, 0, 2, 2, 2, 32'h00003231);
        // reset mid-operation with count=3
        step(1, 2, 32'h00004241, 1, 1, 3, 3, 32'h00333231);
        step(0, 0, 32'h0,        0, 4, 0, 4, 32'h00000000);
        step(0, 0, 32'h0,        0, 4, 0, 4, 32'h00000000);

        waited = 0;
        while (st_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        n_cmp++;
        if (st_q.size() != 0 || data_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d status / %0d words left want 0 / 0", st_q.size(), data_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
